// File: rtl/mem_writeback_cycle.sv
// Purpose : RV32I memory-access + writeback stage; drives a req/ready/rvalid data port, formats loads, registers the RF write triple.
// Latency : non-memory op writes back 1 cycle after acceptance; zero-wait load 3 cycles; store frees the stage the cycle after dmem_ready.
// Backpres: mem_stall (= FSM not IDLE) holds upstream; dmem_req is held with stable addr/we/wdata/wstrb until dmem_ready.
//
// Ports:
//   clk, rst              - rising-edge clock, asynchronous active-high reset
//   in_valid, ex_*        - instruction from execute (ALU result / address, PC+4)
//   dm_*                  - load/store controls, store data, funct3 access type
//   rf_write_*            - writeback controls (enable, rd, data select)
//   dmem_*                - data-memory request/response port (word address, byte strobes)
//   rf_writeback_*        - one-cycle register-file write strobe, rd and data
//   mem_stall             - high whenever a memory transaction is in flight
//   misaligned_fault      - one-cycle pulse for misaligned H/W accesses
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses; otherwise the offending low address bits are cleared.
module mem_writeback_cycle #(
    parameter int XLEN          = 32,
    parameter int REGISTER_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          ex_alu_result,
    input  logic [XLEN-1:0]          ex_pc_plus4,
    input  logic                     dm_read_enable,
    input  logic                     dm_write_enable,
    input  logic [XLEN-1:0]          dm_write_data,
    input  logic [2:0]               dm_load_type,
    input  logic                     rf_write_enable,
    input  logic [REGISTER_SIZE-1:0] rf_write_addr,
    input  logic [1:0]               rf_write_data_sel,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [XLEN-1:0]          dmem_addr,
    output logic [XLEN-1:0]          dmem_wdata,
    output logic [3:0]               dmem_wstrb,
    input  logic                     dmem_ready,
    input  logic                     dmem_rvalid,
    input  logic [XLEN-1:0]          dmem_rdata,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    output logic                     mem_stall,
    output logic                     misaligned_fault
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                   state_q, state_d;
    logic [XLEN-1:0]          addr_q, addr_d;      // byte address with low bits already aligned
    logic [XLEN-1:0]          wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic                     we_q, we_d;
    logic [2:0]               type_q, type_d;
    logic [REGISTER_SIZE-1:0] rd_q, rd_d;
    logic                     rd_en_q, rd_en_d;
    logic                     wb_en_q, wb_en_d;
    logic [REGISTER_SIZE-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]          wb_data_q, wb_data_d;
    logic                     fault_q, fault_d;

    logic                     is_mem;
    logic                     trap;
    logic [XLEN-1:0]          eff_addr;
    logic [3:0]               strb;
    logic [XLEN-1:0]          lane_data;
    logic [XLEN-1:0]          alu_sel_data;
    logic [XLEN-1:0]          rdata_shifted;
    logic [XLEN-1:0]          load_data;

    assign is_mem = dm_read_enable | dm_write_enable;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = ((dm_load_type[1:0] == 2'b01) && ex_alu_result[0]) ||
                  ((dm_load_type[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Clearing the low bits doubles as the non-trapping misalignment fix-up;
    // with trapping enabled, misaligned accesses never reach the capture path.
    always_comb begin
        eff_addr = ex_alu_result;
        case (dm_load_type[1:0])
            2'b01:   eff_addr[0]   = 1'b0;
            2'b10:   eff_addr[1:0] = 2'b00;
            default: ;
        endcase
    end

    // Replicating the store data puts it in every lane; the strobes pick the live one.
    always_comb begin
        case (dm_load_type[1:0])
            2'b00: begin
                strb      = 4'b0001 << eff_addr[1:0];
                lane_data = {4{dm_write_data[7:0]}};
            end
            2'b01: begin
                strb      = 4'b0011 << eff_addr[1:0];
                lane_data = {2{dm_write_data[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                lane_data = dm_write_data;
            end
        endcase
    end

    always_comb begin
        case (rf_write_data_sel)
            2'b10:   alu_sel_data = ex_pc_plus4;
            default: alu_sel_data = ex_alu_result;  // 01 has no load data here; 11 reserved
        endcase
    end

    // Load formatting uses the captured (aligned) address; type_q[2] selects zero extension.
    assign rdata_shifted = dmem_rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        case (type_q[1:0])
            2'b00:   load_data = {{(XLEN-8){~type_q[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){~type_q[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        type_d    = type_q;
        rd_d      = rd_q;
        rd_en_d   = rd_en_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        fault_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_en_d   = rf_write_enable && (rf_write_addr != '0);
                        wb_addr_d = rf_write_addr;
                        wb_data_d = alu_sel_data;
                    end else if (trap) begin
                        fault_d = 1'b1;
                    end else begin
                        addr_d  = eff_addr;
                        wdata_d = lane_data;
                        wstrb_d = strb;
                        we_d    = dm_write_enable;
                        type_d  = dm_load_type;
                        rd_d    = rf_write_addr;
                        rd_en_d = rf_write_enable;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    state_d = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    wb_en_d   = rd_en_q && (rd_q != '0);
                    wb_addr_d = rd_q;
                    wb_data_d = load_data;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            type_q    <= '0;
            rd_q      <= '0;
            rd_en_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            type_q    <= type_d;
            rd_q      <= rd_d;
            rd_en_q   <= rd_en_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            fault_q   <= fault_d;
        end
    end

    // Request and stall come straight from state so reset drops them without waiting for a clock.
    assign dmem_req            = (state_q == REQ);
    assign mem_stall           = (state_q != IDLE);
    assign dmem_we             = we_q;
    assign dmem_addr           = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wdata          = wdata_q;
    assign dmem_wstrb          = wstrb_q;
    assign rf_writeback_enable = wb_en_q;
    assign rf_writeback_addr   = wb_addr_q;
    assign rf_writeback_data   = wb_data_q;
    assign misaligned_fault    = fault_q;

endmodule

// File: tb/tb_mem_writeback_cycle.sv
// Purpose : directed self-checking bench for mem_writeback_cycle.
// Latency : inputs driven on the falling edge, outputs checked on the following falling edges.
// Backpres: dmem_ready / dmem_rvalid driven directly by the stimulus steps.
module tb_mem_writeback_cycle;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc_plus4;
    logic        dm_read_enable;
    logic        dm_write_enable;
    logic [31:0] dm_write_data;
    logic [2:0]  dm_load_type;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [1:0]  rf_write_data_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_writeback_enable;
    logic [4:0]  rf_writeback_addr;
    logic [31:0] rf_writeback_data;
    logic        mem_stall;
    logic        misaligned_fault;

    int vectors = 0;
    int errors  = 0;

    mem_writeback_cycle #(.XLEN(32), .REGISTER_SIZE(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .ex_alu_result       (ex_alu_result),
        .ex_pc_plus4         (ex_pc_plus4),
        .dm_read_enable      (dm_read_enable),
        .dm_write_enable     (dm_write_enable),
        .dm_write_data       (dm_write_data),
        .dm_load_type        (dm_load_type),
        .rf_write_enable     (rf_write_enable),
        .rf_write_addr       (rf_write_addr),
        .rf_write_data_sel   (rf_write_data_sel),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_wstrb          (dmem_wstrb),
        .dmem_ready          (dmem_ready),
        .dmem_rvalid         (dmem_rvalid),
        .dmem_rdata          (dmem_rdata),
        .rf_writeback_enable (rf_writeback_enable),
        .rf_writeback_addr   (rf_writeback_addr),
        .rf_writeback_data   (rf_writeback_data),
        .mem_stall           (mem_stall),
        .misaligned_fault    (misaligned_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid          = 1'b0;
        ex_alu_result     = '0;
        ex_pc_plus4       = '0;
        dm_read_enable    = 1'b0;
        dm_write_enable   = 1'b0;
        dm_write_data     = '0;
        dm_load_type      = 3'b000;
        rf_write_enable   = 1'b0;
        rf_write_addr     = '0;
        rf_write_data_sel = 2'b00;
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [2:0] t, input logic [4:0] rd);
        in_valid          = 1'b1;
        ex_alu_result     = a;
        dm_read_enable    = 1'b1;
        dm_load_type      = t;
        rf_write_enable   = 1'b1;
        rf_write_addr     = rd;
        rf_write_data_sel = 2'b01;
    endtask

    // Zero-wait load: accept, REQ with ready, RESP with rvalid, then writeback.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                           input logic [31:0] rdat, input logic [4:0] rd,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        drive_load(a, t, rd);
        @(negedge clk);
        clear_inputs();
        check({tag, "_req"},   dmem_req,  1);
        check({tag, "_we"},    dmem_we,   0);
        check({tag, "_addr"},  dmem_addr, exp_addr);
        check({tag, "_stall1"}, mem_stall, 1);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check({tag, "_req_resp"}, dmem_req,  0);
        check({tag, "_stall2"},   mem_stall, 1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdat;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check({tag, "_wb_en"},   rf_writeback_enable, 1);
        check({tag, "_wb_addr"}, rf_writeback_addr,   {27'd0, rd});
        check({tag, "_wb_data"}, rf_writeback_data,   exp_data);
        check({tag, "_stall3"},  mem_stall,           0);
    endtask

    initial begin
        clear_inputs();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        rst         = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_req",   dmem_req,            0);
        check("rst_stall", mem_stall,           0);
        check("rst_wb_en", rf_writeback_enable, 0);
        check("rst_addr",  dmem_addr,           0);
        check("rst_wstrb", dmem_wstrb,          0);
        check("rst_fault", misaligned_fault,    0);
        rst = 1'b0;
        @(negedge clk);

        // ADD: ALU result to x5
        in_valid = 1'b1; ex_alu_result = 32'h0000_1234; rf_write_enable = 1'b1;
        rf_write_addr = 5'd5; rf_write_data_sel = 2'b00;
        @(negedge clk);
        clear_inputs();
        check("add_wb_en",   rf_writeback_enable, 1);
        check("add_wb_addr", rf_writeback_addr,   5);
        check("add_wb_data", rf_writeback_data,   32'h0000_1234);
        check("add_stall",   mem_stall,           0);
        check("add_req",     dmem_req,            0);
        @(negedge clk);
        check("add_wb_pulse", rf_writeback_enable, 0);
        check("add_wb_hold",  rf_writeback_data,   32'h0000_1234);

        // Reserved select 11 behaves like ALU result
        in_valid = 1'b1; ex_alu_result = 32'h0000_00AA; ex_pc_plus4 = 32'h0000_0999;
        rf_write_enable = 1'b1; rf_write_addr = 5'd9; rf_write_data_sel = 2'b11;
        @(negedge clk);
        clear_inputs();
        check("sel11_wb_data", rf_writeback_data, 32'h0000_00AA);

        // JAL link with rd=0: no write strobe
        in_valid = 1'b1; ex_pc_plus4 = 32'h0000_0040; ex_alu_result = 32'h0000_0100;
        rf_write_enable = 1'b1; rf_write_addr = 5'd0; rf_write_data_sel = 2'b10;
        @(negedge clk);
        clear_inputs();
        check("jal_x0_wb_en", rf_writeback_enable, 0);

        // JAL link with rd=1
        in_valid = 1'b1; ex_pc_plus4 = 32'h0000_0040; ex_alu_result = 32'h0000_0100;
        rf_write_enable = 1'b1; rf_write_addr = 5'd1; rf_write_data_sel = 2'b10;
        @(negedge clk);
        clear_inputs();
        check("jal_wb_en",   rf_writeback_enable, 1);
        check("jal_wb_data", rf_writeback_data,   32'h0000_0040);

        // Loads: LB sign, LBU, LH sign, LHU
        do_load("lb",  32'h0000_0103, 3'b000, 32'h8012_3456, 5'd7,  32'h0000_0100, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_0101, 3'b100, 32'h1234_F678, 5'd8,  32'h0000_0100, 32'h0000_00F6);
        do_load("lh",  32'h0000_0100, 3'b001, 32'h1234_8001, 5'd10, 32'h0000_0100, 32'hFFFF_8001);
        do_load("lhu", 32'h0000_0102, 3'b101, 32'h8765_4321, 5'd11, 32'h0000_0100, 32'h0000_8765);

        // SH at 0x102, ready delayed 3 cycles -> req held 4 cycles
        in_valid = 1'b1; ex_alu_result = 32'h0000_0102; dm_write_enable = 1'b1;
        dm_write_data = 32'h0000_ABCD; dm_load_type = 3'b001;
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            check("sh_req",   dmem_req,   1);
            check("sh_stall", mem_stall,  1);
            if (i == 0) begin
                check("sh_we",    dmem_we,           1);
                check("sh_addr",  dmem_addr,         32'h0000_0100);
                check("sh_wstrb", dmem_wstrb,        4'b1100);
                check("sh_wdata", dmem_wdata[31:16], 16'hABCD);
            end
            if (i == 3) dmem_ready = 1'b1;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        check("sh_req_done", dmem_req,            0);
        check("sh_stall_done", mem_stall,         0);
        check("sh_no_wb",    rf_writeback_enable, 0);

        // SB at 0x101, zero-wait
        in_valid = 1'b1; ex_alu_result = 32'h0000_0101; dm_write_enable = 1'b1;
        dm_write_data = 32'h1234_565A; dm_load_type = 3'b000;
        @(negedge clk);
        clear_inputs();
        check("sb_wstrb", dmem_wstrb, 4'b0010);
        check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        check("sb_addr",  dmem_addr,  32'h0000_0100);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("sb_stall_done", mem_stall, 0);

        // LW at misaligned 0x202
`ifdef MEM_MISALIGN_TRAP_EN
        drive_load(32'h0000_0202, 3'b010, 5'd12);
        @(negedge clk);
        clear_inputs();
        check("lw_mis_fault", misaligned_fault,    1);
        check("lw_mis_req",   dmem_req,            0);
        check("lw_mis_stall", mem_stall,           0);
        check("lw_mis_wb",    rf_writeback_enable, 0);
        @(negedge clk);
        check("lw_mis_pulse", misaligned_fault,    0);
`else
        do_load("lw_mis", 32'h0000_0202, 3'b010, 32'hDEAD_BEEF, 5'd12, 32'h0000_0200, 32'hDEAD_BEEF);
        check("lw_mis_fault", misaligned_fault, 0);
`endif

        // Reset while in REQ: request drops without a clock edge
        in_valid = 1'b1; ex_alu_result = 32'h0000_0300; dm_write_enable = 1'b1;
        dm_write_data = 32'h1111_2222; dm_load_type = 3'b010;
        @(negedge clk);
        clear_inputs();
        check("rstreq_req_before", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("rstreq_req_after",   dmem_req,  0);
        check("rstreq_stall_after", mem_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset while in RESP: stall drops, late rvalid ignored
        drive_load(32'h0000_0400, 3'b010, 5'd13);
        @(negedge clk);
        clear_inputs();
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("rstresp_stall_before", mem_stall, 1);
        rst = 1'b1;
        #1;
        check("rstresp_stall_after", mem_stall, 0);
        check("rstresp_req_after",   dmem_req,  0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rstresp_no_wb",    rf_writeback_enable, 0);
        check("rstresp_stall_end", mem_stall,          0);
        check("rstresp_wb_data",  rf_writeback_data,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
